// File: rtl/ctrl_in_mux.sv
// ctrl_in_mux: synchronizes and glitch-filters ext_in, routes selected inputs to start/stop/restart triggers; CTRL_IN_HOLDOFF_EN adds per-destination edge hold-off
module ctrl_in_mux #(
  parameter int REG_WIDTH = 32,
  parameter int NUM_IN = 3,
  parameter int FILT_BITS = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [REG_WIDTH-1:0] ctrl_in0,
  input  logic [REG_WIDTH-1:0] ctrl_in1,
  input  logic [NUM_IN-1:0]    ext_in,
  output logic                 trg_start,
  output logic                 trg_stop,
  output logic                 trg_restart,
  output logic [NUM_IN-1:0]    in_state,
  output logic                 ready
);
  logic [NUM_IN-1:0] s1_q, s1_d, s2_q, s2_d, f_q, f_d, fd_q, fd_d, rise, fall;
  logic [FILT_BITS-1:0] cnt_q [NUM_IN];
  logic [FILT_BITS-1:0] cnt_d [NUM_IN];
  logic [FILT_BITS-1:0] n_m1;
  logic [1:0] blank_q, blank_d;
  logic ready_q, ready_d;
  logic [2:0] trg_q, trg_d, hit;
  logic [2:0] src [3];
  logic [1:0] mode [3];
  logic [7:0] rise_v, fall_v, lvl_v, val_v;
  logic unused;
`ifdef CTRL_IN_HOLDOFF_EN
  logic [7:0] hold_q [3];
  logic [7:0] hold_d [3];
`endif
  assign unused = ^{ctrl_in0, ctrl_in1};
  assign n_m1 = (ctrl_in1[FILT_BITS-1:0] == '0) ? '0 : ctrl_in1[FILT_BITS-1:0] - FILT_BITS'(1);
  assign rise = f_q & ~fd_q;
  assign fall = ~f_q & fd_q;
  // Bit 0 of each vector stands for SRC=0 and bits above NUM_IN stay 0, so SRC indexes directly
  assign rise_v = 8'({rise, 1'b0});
  assign fall_v = 8'({fall, 1'b0});
  assign lvl_v = 8'({f_q, 1'b0});
  assign val_v = 8'({{NUM_IN{1'b1}}, 1'b0});
  // Synchronizer, glitch filter and startup blanking counter
  always_comb begin
    s1_d = ext_in;
    s2_d = s1_q;
    fd_d = f_q;
    f_d = f_q;
    blank_d = ready_q ? blank_q : blank_q + 2'd1;
    ready_d = ready_q | (blank_q == 2'd3);
    for (int i = 0; i < NUM_IN; i++) begin
      cnt_d[i] = '0;
      if (!ready_q) f_d[i] = s2_q[i];
      else if (s2_q[i] != f_q[i] && cnt_q[i] >= n_m1) f_d[i] = s2_q[i];
      else if (s2_q[i] != f_q[i]) cnt_d[i] = cnt_q[i] + FILT_BITS'(1);
    end
  end
  // Per-destination source/condition select
  always_comb begin
    for (int d = 0; d < 3; d++) begin
      src[d] = ctrl_in0[8*d +: 3];
      mode[d] = ctrl_in0[8*d+3 +: 2];
      hit[d] = val_v[src[d]] & (mode[d] == 2'd0 ? rise_v[src[d]] :
                                mode[d] == 2'd1 ? fall_v[src[d]] :
                                mode[d] == 2'd2 ? lvl_v[src[d]] : ~lvl_v[src[d]]);
    end
  end
`ifdef CTRL_IN_HOLDOFF_EN
  // Edge pulses reload the hold-off counter; a nonzero counter masks further edge pulses
  always_comb begin
    for (int d = 0; d < 3; d++) begin
      trg_d[d] = ready_q & hit[d] & (mode[d][1] | (hold_q[d] == 8'd0));
      hold_d[d] = !ready_q ? 8'd0 :
                  (trg_d[d] & ~mode[d][1]) ? ctrl_in1[15:8] :
                  (hold_q[d] != 8'd0) ? hold_q[d] - 8'd1 : 8'd0;
    end
  end
`else
  // Triggers are held low while blanking
  always_comb trg_d = {3{ready_q}} & hit;
`endif
  // State registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
      f_q <= '0;
      fd_q <= '0;
      for (int i = 0; i < NUM_IN; i++) cnt_q[i] <= '0;
      blank_q <= '0;
      ready_q <= 1'b0;
      trg_q <= '0;
`ifdef CTRL_IN_HOLDOFF_EN
      for (int d = 0; d < 3; d++) hold_q[d] <= '0;
`endif
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      f_q <= f_d;
      fd_q <= fd_d;
      for (int i = 0; i < NUM_IN; i++) cnt_q[i] <= cnt_d[i];
      blank_q <= blank_d;
      ready_q <= ready_d;
      trg_q <= trg_d;
`ifdef CTRL_IN_HOLDOFF_EN
      for (int d = 0; d < 3; d++) hold_q[d] <= hold_d[d];
`endif
    end
  end
  assign trg_start = trg_q[0];
  assign trg_stop = trg_q[1];
  assign trg_restart = trg_q[2];
  assign in_state = f_q;
  assign ready = ready_q;
endmodule

// File: tb/tb_ctrl_in_mux.sv
// tb_ctrl_in_mux: directed scenarios plus randomized run against a window-based reference model
module tb_ctrl_in_mux;
  logic clock = 0, reset_n = 0;
  logic [31:0] ctrl_in0 = 0, ctrl_in1 = 0;
  logic [2:0] ext_in = 0;
  logic trg_start, trg_stop, trg_restart, ready;
  logic [2:0] in_state;
  int ntests = 0, nfail = 0;

  always #5 clock = ~clock;

  ctrl_in_mux dut (
    .clock(clock), .reset_n(reset_n), .ctrl_in0(ctrl_in0), .ctrl_in1(ctrl_in1),
    .ext_in(ext_in), .trg_start(trg_start), .trg_stop(trg_stop), .trg_restart(trg_restart),
    .in_state(in_state), .ready(ready)
  );

  // Reference model: filtered level changes once the last Neff synchronized samples all
  // agree on a value different from the current level; triggers follow one cycle later.
  logic [255:0] m_h [3];
  logic [255:0] m_msk;
  logic [2:0] m_s1, m_s2, m_f, m_fp, m_trg, m_nf;
  logic m_ready;
  int m_e, m_src, m_md, m_neff;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 = 0; m_s2 = 0; m_f = 0; m_fp = 0; m_trg = 0; m_e = 0; m_ready = 0;
      for (int i = 0; i < 3; i++) m_h[i] = 0;
    end else begin
      for (int d = 0; d < 3; d++) begin
        m_src = int'(ctrl_in0[8*d +: 3]);
        m_md = int'(ctrl_in0[8*d+3 +: 2]);
        if (!m_ready || m_src == 0 || m_src > 3) m_trg[d] = 0;
        else if (m_md == 0) m_trg[d] = m_f[m_src-1] & ~m_fp[m_src-1];
        else if (m_md == 1) m_trg[d] = ~m_f[m_src-1] & m_fp[m_src-1];
        else if (m_md == 2) m_trg[d] = m_f[m_src-1];
        else m_trg[d] = ~m_f[m_src-1];
      end
      m_neff = (ctrl_in1[7:0] == 0) ? 1 : int'(ctrl_in1[7:0]);
      m_msk = (256'd1 << m_neff) - 256'd1;
      for (int i = 0; i < 3; i++) begin
        m_h[i] = {m_h[i][254:0], m_s2[i]};
        m_nf[i] = m_f[i];
        if (!m_ready) m_nf[i] = m_s2[i];
        else if (m_s2[i] != m_f[i] && (m_h[i] & m_msk) == (m_s2[i] ? m_msk : 256'd0)) m_nf[i] = m_s2[i];
      end
      m_fp = m_f; m_f = m_nf; m_s2 = m_s1; m_s1 = ext_in;
      m_e++;
      m_ready = (m_e >= 4);
    end
  end

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic test_reset;
    ctrl_in0 = 32'h01; ctrl_in1 = 0; ext_in = 3'b001;
    @(negedge clock); reset_n = 0; #1;
    ntests++;
    if ({trg_start, trg_stop, trg_restart, ready, in_state} !== 7'b0) begin
      nfail++; $display("FAIL reset_outputs got %b exp 0", {trg_start, trg_stop, trg_restart, ready, in_state});
    end
    repeat (2) @(negedge clock);
    reset_n = 1; #1;
    ntests++;
    if ({trg_start, ready, in_state} !== 5'b0) begin
      nfail++; $display("FAIL release_outputs got %b exp 0", {trg_start, ready, in_state});
    end
    for (int t = 1; t <= 8; t++) begin
      tick;
      ntests++;
      if (ready !== (t >= 4)) begin nfail++; $display("FAIL blank_ready t=%0d got %b exp %b", t, ready, t >= 4); end
      ntests++;
      if (trg_start !== 1'b0) begin nfail++; $display("FAIL blank_trg t=%0d got %b exp 0", t, trg_start); end
      ntests++;
      if (in_state[0] !== (t >= 3)) begin nfail++; $display("FAIL blank_state t=%0d got %b exp %b", t, in_state[0], t >= 3); end
    end
  endtask

  task automatic test_latency;
    for (int a = 0; a < 3; a++) begin
      int n, neff;
      n = (a == 2) ? 3 : a;
      neff = (n == 0) ? 1 : n;
      ctrl_in0 = 32'h01; ctrl_in1 = n; ext_in = 0;
      repeat (8) tick;
      ext_in[0] = 1;
      for (int t = 1; t <= neff + 5; t++) begin
        tick;
        ntests++;
        if (trg_start !== (t == neff + 3)) begin nfail++; $display("FAIL latency_trg n=%0d t=%0d got %b exp %b", n, t, trg_start, t == neff + 3); end
        ntests++;
        if (in_state[0] !== (t >= neff + 2)) begin nfail++; $display("FAIL latency_state n=%0d t=%0d got %b exp %b", n, t, in_state[0], t >= neff + 2); end
      end
      ext_in = 0;
    end
  endtask

  task automatic test_filter;
    ctrl_in0 = 32'h0200; ctrl_in1 = 5; ext_in = 0;
    repeat (8) tick;
    ext_in[1] = 1;
    repeat (4) tick;
    ext_in[1] = 0;
    for (int t = 1; t <= 12; t++) begin
      tick;
      ntests++;
      if ({trg_stop, in_state[1]} !== 2'b00) begin nfail++; $display("FAIL short_pulse t=%0d got %b exp 00", t, {trg_stop, in_state[1]}); end
    end
    ext_in[1] = 1;
    for (int t = 1; t <= 16; t++) begin
      tick;
      ntests++;
      if (trg_stop !== (t == 8)) begin nfail++; $display("FAIL long_pulse_trg t=%0d got %b exp %b", t, trg_stop, t == 8); end
      ntests++;
      if (in_state[1] !== (t >= 7 && t <= 11)) begin nfail++; $display("FAIL long_pulse_state t=%0d got %b exp %b", t, in_state[1], t >= 7 && t <= 11); end
      if (t == 5) ext_in[1] = 0;
    end
  endtask

  task automatic test_level;
    logic q[$];
    logic v, ei, et;
    ctrl_in0 = 32'h1B0000; ctrl_in1 = 0; ext_in = 0;
    repeat (8) tick;
    for (int t = 0; t < 30; t++) begin
      v = 1'($urandom);
      ext_in[2] = v;
      q.push_back(v);
      tick;
      ei = (t >= 2) ? q[t-2] : 1'b0;
      et = ~((t >= 3) ? q[t-3] : 1'b0);
      ntests++;
      if (in_state[2] !== ei) begin nfail++; $display("FAIL level_state t=%0d got %b exp %b", t, in_state[2], ei); end
      ntests++;
      if (trg_restart !== et) begin nfail++; $display("FAIL level_low t=%0d got %b exp %b", t, trg_restart, et); end
    end
    ctrl_in0 = 32'h1F0000;
    for (int t = 0; t < 6; t++) begin
      ext_in[2] = 1'($urandom);
      tick;
      ntests++;
      if (trg_restart !== 1'b0) begin nfail++; $display("FAIL src_none t=%0d got %b exp 0", t, trg_restart); end
    end
  endtask

  task automatic test_reselect;
    ctrl_in0 = 32'h02; ctrl_in1 = 0; ext_in = 3'b001;
    repeat (8) tick;
    ctrl_in0 = 32'h01;
    for (int t = 1; t <= 8; t++) begin
      tick;
      ntests++;
      if (trg_start !== 1'b0) begin nfail++; $display("FAIL reselect t=%0d got %b exp 0", t, trg_start); end
    end
    ext_in = 0; ctrl_in0 = 32'h0101;
    repeat (8) tick;
    ext_in[0] = 1;
    for (int t = 1; t <= 6; t++) begin
      tick;
      ntests++;
      if ({trg_start, trg_stop} !== {2{t == 4}}) begin nfail++; $display("FAIL shared_src t=%0d got %b exp %b", t, {trg_start, trg_stop}, {2{t == 4}}); end
    end
    ext_in = 0;
  endtask

  task automatic test_holdoff;
    logic e;
    ctrl_in0 = 32'h01; ctrl_in1 = 32'h0A00; ext_in = 0;
    repeat (16) tick;
    for (int t = 1; t <= 24; t++) begin
      ext_in[0] = (t == 1 || t == 2 || t == 5 || t == 6 || t == 17 || t == 18);
      tick;
`ifdef CTRL_IN_HOLDOFF_EN
      e = (t == 4 || t == 20);
`else
      e = (t == 4 || t == 8 || t == 20);
`endif
      ntests++;
      if (trg_start !== e) begin nfail++; $display("FAIL holdoff t=%0d got %b exp %b", t, trg_start, e); end
    end
    ext_in = 0; ctrl_in1 = 0;
  endtask

  task automatic test_random;
    for (int r = 0; r < 2; r++) begin
      ctrl_in1 = {16'($urandom), 8'h00, 8'($urandom_range(0, 4))};
      ctrl_in0 = $urandom;
      @(negedge clock); reset_n = 0;
      repeat (2) tick;
      reset_n = 1;
      for (int c = 0; c < 300; c++) begin
        if (c % 25 == 0) ctrl_in0 = $urandom;
        if (c == 150) reset_n = 0;
        if (c == 152) reset_n = 1;
        if ($urandom_range(0, 2) == 0) ext_in = 3'($urandom);
        tick;
        ntests++;
        if ({trg_restart, trg_stop, trg_start, in_state, ready} !== {m_trg, m_f, m_ready}) begin
          nfail++;
          $display("FAIL random r=%0d c=%0d got %b exp %b", r, c, {trg_restart, trg_stop, trg_start, in_state, ready}, {m_trg, m_f, m_ready});
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_filter;
    test_level;
    test_reselect;
    test_holdoff;
    test_random;
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
